// File: rtl/pp_rowwin3_if.sv
// pp_rowwin3_if: upstream FIFO read port and downstream pixel-triple stream of pp_rowwin3
interface pp_rowwin3_if #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_WIDTH  = 640,
  parameter int FILL_WIDTH = 11
);
  localparam int CW = $clog2(IMG_WIDTH);
  logic                  o_rd;
  logic [DATA_WIDTH-1:0] i_data;
  logic [FILL_WIDTH-1:0] i_fill;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_top;
  logic [DATA_WIDTH-1:0] o_mid;
  logic [DATA_WIDTH-1:0] o_bot;
  logic [CW-1:0]         o_col;
  logic                  o_sol;
  logic                  o_eol;
  logic                  o_eof;
  modport master (
    output o_rd, o_valid, o_top, o_mid, o_bot, o_col, o_sol, o_eol, o_eof,
    input  i_data, i_fill
  );
  modport slave (
    input  o_rd, o_valid, o_top, o_mid, o_bot, o_col, o_sol, o_eol, o_eof,
    output i_data, i_fill
  );
endinterface

// File: rtl/pp_rowwin3.sv
// pp_rowwin3: buffers the three latest image rows from the preprocess FIFO and streams top/mid/bot pixel triples
module pp_rowwin3 #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FILL_WIDTH = 11
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_flush,
  pp_rowwin3_if.master io
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_PEN  = CW'(IMG_WIDTH - 2);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_HEIGHT);
  typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;
  state_t                r_state;
  state_t                w_state_nx;
  logic [DATA_WIDTH-1:0] r_mem [3][IMG_WIDTH];
  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_ocol;
  logic [RW-1:0]         r_row;
  logic [1:0]            r_wb;
  logic                  r_arm;
  logic                  r_rd;
  logic                  r_rd_d1;
  logic                  r_valid;
  logic                  r_sol;
  logic                  r_eol;
  logic                  r_eof;
  logic [DATA_WIDTH-1:0] r_top;
  logic [DATA_WIDTH-1:0] r_mid;
  logic [DATA_WIDTH-1:0] r_bot;
  logic                  w_fill_ok;
  logic                  w_start;
  logic                  w_last_wr;
  logic                  w_last_em;
  logic                  w_frame_end;
  logic                  w_rd_nx;
  logic [RW-1:0]         w_row_inc;
  logic [1:0]            w_b1;
  logic [1:0]            w_b2;
  // r_arm keeps o_rd low for the first cycle after reset or flush is released
  always_comb begin
    w_fill_ok   = io.i_fill >= FILL_WIDTH'(IMG_WIDTH);
    w_start     = r_arm && w_fill_ok;
    w_last_wr   = r_rd_d1 && r_col == COL_LAST;
    w_last_em   = r_state == EMIT && r_col == COL_LAST;
    w_frame_end = w_last_em && r_row == ROW_END;
    w_row_inc   = r_row + 1'b1;
    w_b1        = r_wb == 2'd2 ? 2'd0 : r_wb + 2'd1;
    w_b2        = r_wb == 2'd0 ? 2'd2 : r_wb - 2'd1;
    w_rd_nx     = r_state == IDLE ? w_start : r_state == READ && r_rd && !(r_rd_d1 && r_col == COL_PEN);
    w_state_nx  = r_state == IDLE ? (w_start ? READ : IDLE) :
                  r_state == READ ? (w_last_wr ? (w_row_inc >= RW'(3) ? EMIT : IDLE) : READ) :
                  (w_last_em ? IDLE : EMIT);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (i_rstn && !i_flush && r_rd_d1) r_mem[r_wb][r_col] <= io.i_data;
  end
  // r_wb is the next buffer to fill, so the row just written sits in w_b2
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) begin
      r_arm   <= 1'b0;
      r_rd    <= 1'b0;
      r_rd_d1 <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_wb    <= 2'd0;
      r_valid <= 1'b0;
      r_ocol  <= '0;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_top   <= '0;
      r_mid   <= '0;
      r_bot   <= '0;
    end else begin
      r_arm   <= 1'b1;
      r_rd    <= w_rd_nx;
      r_rd_d1 <= r_rd;
      r_col   <= (w_last_wr || w_last_em) ? '0 : (r_rd_d1 || r_state == EMIT) ? r_col + 1'b1 : r_col;
      r_row   <= w_last_wr ? w_row_inc : w_frame_end ? '0 : r_row;
      r_wb    <= w_last_wr ? w_b1 : w_frame_end ? 2'd0 : r_wb;
      r_valid <= r_state == EMIT;
      r_ocol  <= r_state == EMIT ? r_col : '0;
      r_sol   <= r_state == EMIT && r_col == '0;
      r_eol   <= w_last_em;
      r_eof   <= r_eol && r_row == '0;
      r_top   <= r_state == EMIT ? r_mem[r_wb][r_col] : '0;
      r_mid   <= r_state == EMIT ? r_mem[w_b1][r_col] : '0;
      r_bot   <= r_state == EMIT ? r_mem[w_b2][r_col] : '0;
    end
  end
  assign io.o_rd    = r_rd;
  assign io.o_valid = r_valid;
  assign io.o_top   = r_top;
  assign io.o_mid   = r_mid;
  assign io.o_bot   = r_bot;
  assign io.o_col   = r_ocol;
  assign io.o_sol   = r_sol;
  assign io.o_eol   = r_eol;
  assign io.o_eof   = r_eof;
endmodule

// File: tb/tb_pp_rowwin3.sv
// tb_pp_rowwin3: directed bench for pp_rowwin3 with 4-pixel rows, 4-row (dut_a) and 6-row (dut_b) frames
module tb_pp_rowwin3;
  localparam int DW = 12;
  localparam int W  = 4;
  localparam int FW = 11;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic use_b = 1'b0;
  int checks = 0;
  int failures = 0;
  int vseen = 0;
  int base_a = 0;
  int na = 0;
  int nb = 0;
  always #5 clk = ~clk;
  pp_rowwin3_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .FILL_WIDTH(FW)) ia ();
  pp_rowwin3_if #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .FILL_WIDTH(FW)) ib ();
  pp_rowwin3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(4), .FILL_WIDTH(FW)) dut_a (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .io(ia)
  );
  pp_rowwin3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(6), .FILL_WIDTH(FW)) dut_b (
    .i_clk(clk), .i_rstn(rstn), .i_flush(1'b0), .io(ib)
  );
  // upstream FIFO models: read data appears the cycle after o_rd
  always @(posedge clk) if (ia.o_rd) begin ia.i_data <= DW'(base_a + na); na <= na + 1; end
  always @(posedge clk) if (ib.o_rd) begin ib.i_data <= DW'(nb); nb <= nb + 1; end
  logic          s_rd, s_valid, s_sol, s_eol, s_eof;
  logic [DW-1:0] s_top, s_mid, s_bot;
  logic [1:0]    s_col;
  assign s_rd    = use_b ? ib.o_rd    : ia.o_rd;
  assign s_valid = use_b ? ib.o_valid : ia.o_valid;
  assign s_sol   = use_b ? ib.o_sol   : ia.o_sol;
  assign s_eol   = use_b ? ib.o_eol   : ia.o_eol;
  assign s_eof   = use_b ? ib.o_eof   : ia.o_eof;
  assign s_top   = use_b ? ib.o_top   : ia.o_top;
  assign s_mid   = use_b ? ib.o_mid   : ia.o_mid;
  assign s_bot   = use_b ? ib.o_bot   : ia.o_bot;
  assign s_col   = use_b ? ib.o_col   : ia.o_col;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic rd_burst(input string tag);
    int n = 0;
    int t = 0;
    while (!s_rd && t < 60) begin
      @(negedge clk);
      t++;
      if (s_valid) vseen++;
    end
    while (s_rd && n < 60) begin
      n++;
      if (s_valid) vseen++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, W);
  endtask
  task automatic emit_row(input string tag, input int t0, input int eof_exp);
    int t = 0;
    while (!s_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    for (int c = 0; c < W; c++) begin
      chk($sformatf("%s_v%0d", tag, c), int'(s_valid), 1);
      chk($sformatf("%s_top%0d", tag, c), int'(s_top), t0 + c);
      chk($sformatf("%s_mid%0d", tag, c), int'(s_mid), t0 + W + c);
      chk($sformatf("%s_bot%0d", tag, c), int'(s_bot), t0 + 2 * W + c);
      chk($sformatf("%s_col%0d", tag, c), int'(s_col), c);
      chk($sformatf("%s_sol%0d", tag, c), int'(s_sol), int'(c == 0));
      chk($sformatf("%s_eol%0d", tag, c), int'(s_eol), int'(c == W - 1));
      chk($sformatf("%s_rd%0d", tag, c), int'(s_rd), 0);
      @(negedge clk);
    end
    chk({tag, "_vend"}, int'(s_valid), 0);
    chk({tag, "_eof"}, int'(s_eof), eof_exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int t;
    int cnt;
    ia.i_fill = FW'(W);
    ib.i_fill = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd", int'(s_rd), 0);
    chk("rst_zero", int'(|{s_valid, s_sol, s_eol, s_eof, s_top, s_mid, s_bot, s_col}), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_rd1", int'(s_rd), 0);
    @(negedge clk);
    chk("rel_rd2", int'(s_rd), 1);
    // frame 1: pixels 0..15
    vseen = 0;
    rd_burst("f1_r0");
    rd_burst("f1_r1");
    rd_burst("f1_r2");
    chk("f1_novalid", vseen, 0);
    emit_row("f1_e2", 0, 0);
    rd_burst("f1_r3");
    base_a = 100 - na;
    emit_row("f1_e3", 4, 1);
    // frame 2: pixels 100..115, flushed mid-row
    vseen = 0;
    rd_burst("f2_r0");
    rd_burst("f2_r1");
    rd_burst("f2_r2");
    chk("f2_novalid", vseen, 0);
    emit_row("f2_e2", 100, 0);
    rd_burst("f2_r3");
    base_a = 200 - na;
    t = 0;
    while (!s_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("fl_top0", int'(s_top), 104);
    @(negedge clk);
    chk("fl_top1", int'(s_top), 105);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_valid", int'(s_valid), 0);
    chk("fl_state", int'(dut_a.r_state), 0);
    chk("fl_rd", int'(s_rd), 0);
    flush = 1'b0;
    @(negedge clk);
    chk("fl_rd_rel", int'(s_rd), 0);
    // frame 3 restarts at row 0
    vseen = 0;
    rd_burst("f3_r0");
    rd_burst("f3_r1");
    rd_burst("f3_r2");
    chk("f3_novalid", vseen, 0);
    emit_row("f3_e2", 200, 0);
    rd_burst("f3_r3");
    ia.i_fill = FW'(3);
    emit_row("f3_e3", 204, 1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_rd) cnt++;
    end
    chk("fill3_rd", cnt, 0);
    ia.i_fill = FW'(W);
    @(negedge clk);
    chk("fill4_rd", int'(s_rd), 1);
    rd_burst("fill4");
    ia.i_fill = '0;
    // 6-row frame exercises buffer rotation wrap
    use_b = 1'b1;
    ib.i_fill = FW'(W);
    vseen = 0;
    rd_burst("b_r0");
    rd_burst("b_r1");
    rd_burst("b_r2");
    chk("b_novalid", vseen, 0);
    emit_row("b_e2", 0, 0);
    rd_burst("b_r3");
    emit_row("b_e3", 4, 0);
    rd_burst("b_r4");
    emit_row("b_e4", 8, 0);
    rd_burst("b_r5");
    emit_row("b_e5", 12, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pp_rowwin3.md
Name: pp_rowwin3

Overview:
- Sits directly downstream of the preprocess output FIFO, which holds RGB444 passthrough or greyscale pixels.
- Pulls whole rows from that FIFO in single bursts and keeps the three most recent rows in on-chip line buffers.
- Streams vertically aligned pixel triples (top/mid/bottom) per column, which the Gaussian/convolution stage uses to build its 3x3 window.
- Tracks row position within the frame, flags line and frame boundaries, and supports a frame flush.

Parameters:
- DATA_WIDTH, 12, pixel width.
- IMG_WIDTH, 640, pixels per row; also the read burst length.
- IMG_HEIGHT, 480, rows per frame.
- FILL_WIDTH, 11, width of the upstream fill count.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_flush  in  1  synchronous frame abort; same effect as reset on all state, with line-buffer RAM contents left as is
- o_rd  out  1  read enable to the upstream FIFO
- i_data  in  DATA_WIDTH  upstream FIFO read data; valid the cycle after o_rd
- i_fill  in  FILL_WIDTH  upstream FIFO fill count
- o_valid  out  1  triple valid
- o_top  out  DATA_WIDTH  pixel from row r-2
- o_mid  out  DATA_WIDTH  pixel from row r-1
- o_bot  out  DATA_WIDTH  pixel from row r
- o_col  out  clog2(IMG_WIDTH)  column of the current triple
- o_sol  out  1  first column of an emitted row, qualified by o_valid
- o_eol  out  1  last column of an emitted row, qualified by o_valid
- o_eof  out  1  one-cycle pulse after the last emitted row of a frame

Behaviour:
- Reset or i_flush:
  - All outputs go to 0.
  - STATE=IDLE; row counter, column counter and write-buffer index wb all go to 0.
  - The o_rd pipeline delay register is cleared.
  - Flush takes priority over every other event in the same cycle.
- Three line RAMs, each IMG_WIDTH x DATA_WIDTH, with a synchronous read of 1-cycle latency. Row n is written into buffer n mod 3.
- State IDLE:
  - If i_fill >= IMG_WIDTH, go to READ.
  - Otherwise o_rd=0.
  - The fill comparison is made only in IDLE; a row burst is never started partially.
- State READ:
  - o_rd=1 for exactly IMG_WIDTH consecutive cycles. o_rd is registered, so it rises 1 cycle after the IDLE decision.
  - rd_d1 (o_rd delayed by 1 cycle) writes i_data into buffer wb at address wcol; wcol increments 0..IMG_WIDTH-1.
  - On the cycle of the last write, the row counter increments and wb advances mod 3.
  - Then: if rows_in_frame >= 3, go to EMIT; else go to IDLE.
- State EMIT:
  - raddr steps 0..IMG_WIDTH-1, one address per cycle, no gaps.
  - The three outputs are registered 1 cycle after the address, giving a triple latency of 1 cycle after raddr.
  - Mapping, where b is the buffer just written: o_bot = buffer b, o_mid = buffer (b+2) mod 3, o_top = buffer (b+1) mod 3.
  - o_valid is high for exactly IMG_WIDTH cycles. o_col = raddr delayed by 1 cycle. o_sol when o_col==0; o_eol when o_col==IMG_WIDTH-1.
  - When the last triple is issued, go to IDLE.
- Per frame: IMG_HEIGHT-2 emitted rows of IMG_WIDTH triples each. Rows 0 and 1 are only loaded, never emitted.
- Frame end:
  - When the row counter reaches IMG_HEIGHT, o_eof pulses in the cycle after the last o_eol.
  - The row counter returns to 0 and wb returns to 0.
  - The next frame needs 3 fresh rows before it emits; buffers are never mixed across frames.
- No read/emit overlap: o_rd=0 throughout EMIT. Upstream backpressure comes only from the fill check.
- No downstream backpressure: the consumer must accept one triple per cycle while o_valid is high.
- i_fill changes during READ are ignored. The upstream FIFO must not underflow, which the fill check guarantees.
- o_rd never asserts in the cycle after reset or flush is released.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4. Preload the FIFO with 16 pixels valued 0..15, i_fill=16.
   - Required: four bursts of exactly 4 o_rd cycles; no o_valid after rows 0 and 1.
   - After row 2: triples (0,4,8),(1,5,9),(2,6,10),(3,7,11), with o_sol on col 0 and o_eol on col 3.
   - After row 3: triples (4,8,12)..(7,11,15), followed by an o_eof pulse the next cycle.
2. i_fill held at 3, then stepped to 4 (IMG_WIDTH=4) -> no o_rd while i_fill=3; an o_rd burst starts 1 cycle after the fill-check cycle that sees 4.
3. Two back-to-back frames, second frame pixels offset by 100 -> frame 2's first emission comes only after its third row, with triple (100,104,108); no frame 1 data appears in frame 2 triples.
4. Assert i_flush in the middle of an EMIT row (after the second o_valid) -> o_valid=0 the next cycle; STATE=IDLE; the next frame restarts at row 0 and emits after 3 rows.
5. Release reset with i_fill=IMG_WIDTH -> all outputs are 0 during reset; o_rd first rises 2 cycles after the release edge.
6. Emission rows with wb wrap (IMG_HEIGHT=6) -> buffer rotation gives correct top/mid/bot ordering for rows 3, 4 and 5 (pixel n = n, e.g. row 5 col 0 gives (12,16,20)).
